// File: rtl/mul_ctrl_defs.sv
// Shared definitions for the sequential 16x16 multiplier controller:
// FSM encoding and iteration/latency constants.
package mul_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int MUL_ITER = 16;
  localparam int MUL_LAT  = 17;

endpackage

// File: rtl/twoscomplement_16bit.sv
// Conditional two's complement of a 16-bit value; passes the input through
// when en is low. Used to turn signed operands into magnitudes.
module twoscomplement_16bit (
  input  logic        en,
  input  logic [15:0] in,
  output logic [15:0] out
);

  assign out = en ? (~in + 16'd1) : in;

endmodule

// File: rtl/seq_mul16_ctrl.sv
// Sequential shift-add 16x16->32 multiplier with start/busy/done handshake.
// Signed operands are reduced to magnitudes and the product negated at the end.
module seq_mul16_ctrl
  import mul_ctrl_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mul_state_t state_q, state_d;

  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic               accept;
  logic               last_iter;

  twoscomplement_16bit u_abs_a (
    .en  (sgn & op_a[WIDTH-1]),
    .in  (op_a),
    .out (mag_a)
  );

  twoscomplement_16bit u_abs_b (
    .en  (sgn & op_b[WIDTH-1]),
    .in  (op_b),
    .out (mag_b)
  );

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last_iter = (cnt_q == 4'(MUL_ITER - 1));
  assign sum       = acc_q[2*WIDTH:WIDTH] + {1'b0, (mplr_q[0] ? mcand_q : '0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == SIGN);
    done = (state_q == DONE);
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (accept) begin
      mcand_d   = mag_a;
      mplr_d    = mag_b;
      neg_d     = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      acc_d     = '0;
      cnt_d     = '0;
      product_d = '0;
    end else if (state_q == RUN) begin
      // Add into the upper half, then shift the whole 33-bit window right.
      acc_d  = {sum, acc_q[WIDTH-1:0]} >> 1;
      mplr_d = mplr_q >> 1;
      cnt_d  = cnt_q + 4'd1;
    end else if (state_q == SIGN) begin
      product_d = neg_q ? (~acc_q[2*WIDTH-1:0] + 32'd1) : acc_q[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mul16_ctrl.sv
// Directed bench for seq_mul16_ctrl: corners, latency, handshake, reset, back-to-back.
module tb_seq_mul16_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_chk = 0;
  int n_err = 0;

  seq_mul16_ctrl #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sgn     (sgn),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for done (bounded), returning cycles counted after the accept edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; sgn = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".clr"}, product, 32'd0);
    wait_done(n);
    chk({tag, ".lat"}, n, 32'd17);
    chk({tag, ".prod"}, product, exp);
    @(posedge clk); #1;
    chk({tag, ".done1"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, product, exp);
  endtask

  initial begin
    int n;
    int busy_lo;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.prod", product, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    run_op("s_m1m1",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    run_op("s_minmin", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run_op("s_min1",   1'b1, 16'h8000, 16'h0001, 32'hFFFF8000);
    run_op("s_7m3",    1'b1, 16'h0007, 16'hFFFD, 32'hFFFFFFEB);
    run_op("u_ffff",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("u_8000x2", 1'b0, 16'h8000, 16'h0002, 32'h00010000);
    run_op("zero",     1'b1, 16'h0000, 16'hFFFB, 32'h00000000);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; op_a = 16'd3; op_b = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.done", 32'(done), 32'd0);
    chk("rstmid.prod", product, 32'd0);
    @(negedge clk) reset = 1'b0;
    run_op("post_rst", 1'b0, 16'd3, 16'd5, 32'h0000000F);

    // Start pulsed during RUN with different operands must be ignored.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; op_a = 16'd100; op_b = 16'd200;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 5) begin start = 1'b1; op_a = 16'd9; op_b = 16'd9; end
      else        start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("hs.lat", n, 32'd17);
    chk("hs.prod", product, 32'h00004E20);
    @(posedge clk); #1;
    chk("hs.done1", 32'(done), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; op_a = 16'd2; op_b = 16'd3;
    @(posedge clk); #1;
    op_a = 16'd4; op_b = 16'd5;
    busy_lo = 0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b.lat1", n, 32'd17);
    chk("b2b.prod1", product, 32'd6);
    n = 0;
    do begin
      if (!busy) busy_lo++;
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    start = 1'b0;
    chk("b2b.gap", n, 32'd18);
    chk("b2b.prod2", product, 32'd20);
    chk("b2b.busylo", busy_lo, 32'd1);
    @(posedge clk); #1;
    chk("b2b.idle", 32'(busy | done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
